spi_flash_reader: RTL

SPI_FLASH_READER -- requirements
Module: spi_flash_reader

---
 rtl/spi_flash_reader.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/spi_flash_reader.sv
// SPI flash word reader: wakes the flash with 0xAB after reset, then serves
// 32-bit little-endian reads using the 0x03 command in SPI mode 0.
module spi_flash_reader #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CSB_GAP = 4
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0,
  input  logic        flash_io1
);

  typedef enum logic [2:0] {WAKE, GAP, IDLE, CMD, ADDR, DATA} state_e;

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [3:0] GAP_LAST = 4'(CSB_GAP - 1);

  state_e      state_q;
  logic        csb_q;
  logic        sclk_q;
  logic        io0_q;
  logic        ready_q;
  logic        busy_q;
  logic        rsp_valid_q;
  logic        last_q;
  logic [31:0] rsp_data_q;
  logic [31:0] rx_q;
  logic [23:0] addr_q;
  logic [23:0] tx_q;
  logic [3:0]  div_q;
  logic [3:0]  gap_q;
  logic [4:0]  bit_q;
  logic [4:0]  field_last_d;
  logic        div_done_d;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = &{1'b0, req_addr[1:0]};

  always_comb begin
    field_last_d = 5'd7;
    case (state_q)
      ADDR:    field_last_d = 5'd23;
      DATA:    field_last_d = 5'd31;
      default: field_last_d = 5'd7;
    endcase
  end

  assign div_done_d = (div_q == DIV_LAST);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q     <= WAKE;
      csb_q       <= 1'b1;
      sclk_q      <= 1'b0;
      io0_q       <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      last_q      <= 1'b0;
      rsp_data_q  <= '0;
      rx_q        <= '0;
      addr_q      <= '0;
      tx_q        <= '0;
      div_q       <= '0;
      gap_q       <= '0;
      bit_q       <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_q + 4'd1;
          end
        end
        IDLE: begin
          if (req_valid) begin
            state_q <= CMD;
            addr_q  <= {req_addr[23:2], 2'b00};
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            csb_q   <= 1'b0;
            tx_q    <= {8'h03, 16'h0000};
            io0_q   <= 1'b0;
            div_q   <= '0;
            bit_q   <= '0;
          end
        end
        default: begin
          // csb still high here only on the first cycle of WAKE after reset
          if (csb_q) begin
            csb_q <= 1'b0;
            tx_q  <= {8'hAB, 16'h0000};
            io0_q <= 1'b1;
            div_q <= '0;
            bit_q <= '0;
          end else if (last_q) begin
            last_q  <= 1'b0;
            csb_q   <= 1'b1;
            io0_q   <= 1'b0;
            gap_q   <= '0;
            state_q <= GAP;
            if (state_q == DATA) begin
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
            end
          end else if (!div_done_d) begin
            div_q <= div_q + 4'd1;
          end else if (!sclk_q) begin
            sclk_q <= 1'b1;
            div_q  <= '0;
            if (state_q == DATA) begin
              rx_q <= {rx_q[30:0], flash_io1};
            end
          end else begin
            sclk_q <= 1'b0;
            div_q  <= '0;
            if (bit_q != field_last_d) begin
              bit_q <= bit_q + 5'd1;
              tx_q  <= {tx_q[22:0], 1'b0};
              io0_q <= tx_q[22];
            end else begin
              bit_q <= '0;
              // Last field of a transaction ends with one clk-low cycle before csb rises
              case (state_q)
                CMD: begin
                  state_q <= ADDR;
                  tx_q    <= addr_q;
                  io0_q   <= addr_q[23];
                end
                ADDR: begin
                  state_q <= DATA;
                  io0_q   <= 1'b0;
                end
                default: last_q <= 1'b1;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign flash_csb = csb_q;
  assign flash_clk = sclk_q;
  assign flash_io0 = io0_q;

endmodule
